// File: rtl/uart_pkg.sv
// uart_pkg -- shared constants for the UART transmit arbiter.
// Holds the 2-bit FSM state encoding, the default data width and start
// timeout, and a small helper that turns a grant index into a ready vector.
package uart_pkg;

   localparam int DATA_W_DEF    = 8;
   localparam int START_TMO_DEF = 16;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE      = 2'd0;
   localparam state_t ST_START     = 2'd1;
   localparam state_t ST_WAIT_BUSY = 2'd2;
   localparam state_t ST_WAIT_DONE = 2'd3;

   // Ready vector {req1, req0}: one-hot on the granted requester, zero if nobody asks.
   function automatic logic [1:0] grant_to_ready(input logic any, input logic gnt);
      logic [1:0] rdy;
      if (!any) begin
         rdy = 2'b00;
      end else if (gnt) begin
         rdy = 2'b10;
      end else begin
         rdy = 2'b01;
      end
      return rdy;
   endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// uart_rr_arb2 -- purely combinational 2-way arbiter.
// i_ptr names the requester that wins when both are valid; a lone valid
// requester always wins.
module uart_rr_arb2 (
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_ptr,
   output logic o_any,
   output logic o_grant
);

   // Pick the winner: the pointer breaks ties, otherwise whoever is asking.
   always_comb begin
      o_any   = i_valid0 | i_valid1;
      o_grant = 1'b0;
      if (i_valid0 && i_valid1) begin
         o_grant = i_ptr;
      end else if (i_valid1) begin
         o_grant = 1'b1;
      end else begin
         o_grant = 1'b0;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter -- shares one UART transmitter between two byte requesters.
// Accepts one byte in IDLE, pulses tx_start, waits for tx_busy to rise
// (bounded by START_TMO cycles, sticky tmo_err on expiry) and to fall again.
// Build option: define UART_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// wins ties, no pointer register); otherwise ties alternate round-robin.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int START_TMO = START_TMO_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0_valid,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              tx_start,
   output logic [DATA_W-1:0] tx_data,
   input  logic              tx_busy,
   output logic              grant,
   output logic              active,
   output logic              tmo_err
);

   localparam int              CNT_W    = $clog2(START_TMO) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TMO - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t              r_state;
   logic                r_tx_start;
   logic [DATA_W-1:0]   r_tx_data;
   logic                r_grant;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_tmo_err;
   logic                w_any;
   logic                w_gnt;
   logic                w_ptr;
   logic [CNT_W-1:0]    w_cnt_inc;
   logic                w_done;

   assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : (r_cnt + CNT_ONE);
   assign w_done    = (r_state == ST_WAIT_DONE) && !tx_busy;

   uart_rr_arb2 u_arb (
      .i_valid0 (req0_valid),
      .i_valid1 (req1_valid),
      .i_ptr    (w_ptr),
      .o_any    (w_any),
      .o_grant  (w_gnt)
   );

`ifdef UART_ARB_FIXED_PRIO_EN
   assign w_ptr = 1'b0;
`else
   logic r_ptr;

   // r_ptr holds the tie-winner for the next request; it is the complement of
   // the last successful grant, so the reset value 0 lets requester 0 win first.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr <= 1'b0;
      end else if (w_done) begin
         r_ptr <= ~r_grant;
      end else begin
         r_ptr <= r_ptr;
      end
   end

   assign w_ptr = r_ptr;
`endif

   // Readies are combinational in IDLE and forced low while reset is held.
   always_comb begin
      {req1_ready, req0_ready} = 2'b00;
      if (reset && (r_state == ST_IDLE)) begin
         {req1_ready, req0_ready} = grant_to_ready(w_any, w_gnt);
      end else begin
         {req1_ready, req0_ready} = 2'b00;
      end
   end

   // Transfer FSM: accept, start pulse, wait for busy (with timeout), wait for done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_tx_start <= 1'b0;
         r_tx_data  <= '0;
         r_grant    <= 1'b0;
         r_cnt      <= '0;
         r_tmo_err  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_tx_data  <= w_gnt ? req1_data : req0_data;
                  r_grant    <= w_gnt;
                  r_tx_start <= 1'b1;
                  r_state    <= ST_START;
               end else begin
                  r_tx_start <= 1'b0;
               end
            end
            ST_START: begin
               r_tx_start <= 1'b0;
               r_cnt      <= '0;
               r_state    <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (tx_busy) begin
                  r_state <= ST_WAIT_DONE;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc >= CNT_LAST) begin
                     r_tmo_err <= 1'b1;
                     r_state   <= ST_IDLE;
                  end else begin
                     r_state <= ST_WAIT_BUSY;
                  end
               end
            end
            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_WAIT_DONE;
               end
            end
            default: begin
               r_tx_start <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
   assign grant    = r_grant;
   assign tmo_err  = r_tmo_err;
   assign active   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter -- self-checking bench for uart_tx_arbiter.
// A table of requests is applied one transfer at a time; a scoreboard queue
// holds the predicted {grant, byte} and a monitor compares it on tx_start.
// Hand-written sequences cover timeout and reset in the middle of a transfer.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   localparam int BUSY_DLY = 2;
   localparam int BUSY_LEN = 20;

   typedef struct {
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic       g_rr;
      logic       g_fx;
   } vec_t;

   typedef struct {
      logic       g;
      logic [7:0] d;
   } exp_t;

   logic       clk;
   logic       reset;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic       grant;
   logic       active;
   logic       tmo_err;

   int   checks;
   int   errors;
   bit   uart_en;
   int   m_cnt;
   exp_t sb_q[$];
   vec_t tbl[9];

   uart_tx_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_busy    (tx_busy),
      .grant      (grant),
      .active     (active),
      .tmo_err    (tmo_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_next(int cur, bit start);
      int n;
      if (start) n = 1;
      else if (cur > 0) n = cur + 1;
      else n = 0;
      if (n >= BUSY_DLY + BUSY_LEN) n = 0;
      return n;
   endfunction

   // UART model: busy rises BUSY_DLY cycles after tx_start and lasts BUSY_LEN cycles.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_cnt   <= 0;
         tx_busy <= 1'b0;
      end else begin
         m_cnt   <= model_next(m_cnt, tx_start && uart_en);
         tx_busy <= (model_next(m_cnt, tx_start && uart_en) >= BUSY_DLY);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every start pulse must match the oldest prediction.
   always @(negedge clk) begin
      if (reset && tx_start) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected_start", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("sb_tx_data", {24'd0, tx_data}, {24'd0, e.d});
            chk("sb_grant", {31'd0, grant}, {31'd0, e.g});
         end
      end
   end

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic to_sample();
      @(negedge clk);
   endtask

   task automatic run_xfer(input vec_t v, input string tag);
      logic       g;
      logic [7:0] d;
      exp_t       e;
      bit         seen_busy;
      bit         done;
      g = FIXED ? v.g_fx : v.g_rr;
      d = g ? v.d1 : v.d0;
      to_drive();
      req0_valid = v.v0; req0_data = v.d0;
      req1_valid = v.v1; req1_data = v.d1;
      to_sample();
      chk({tag, "_idle"}, {31'd0, active}, 32'd0);
      chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, g ? 32'd2 : 32'd1);
      e.g = g; e.d = d;
      sb_q.push_back(e);
      // hold both valids high for the whole transfer: back-pressure
      to_drive();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      to_sample();
      chk({tag, "_start"}, {31'd0, tx_start}, 32'd1);
      chk({tag, "_ready_start"}, {30'd0, req1_ready, req0_ready}, 32'd0);
      seen_busy = 1'b0;
      done = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         to_drive();
         to_sample();
         chk({tag, "_bp_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
         chk({tag, "_one_pulse"}, {31'd0, tx_start}, 32'd0);
         chk({tag, "_active"}, {31'd0, active}, 32'd1);
         chk({tag, "_stable"}, {24'd0, tx_data}, {24'd0, d});
         if (tx_busy) seen_busy = 1'b1;
         else if (seen_busy) done = 1'b1;
      end
      if (!done) chk({tag, "_busy_fall_timeout"}, 32'd0, 32'd1);
   endtask

   // Watchdog so a stuck design can never hang the run.
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      checks = 0; errors = 0; uart_en = 1'b1;
      tbl[0] = '{1'b1, 8'hF0, 1'b1, 8'h0F, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 8'hF0, 1'b1, 8'h0F, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 8'hF0, 1'b1, 8'h0F, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 8'hF0, 1'b1, 8'h0F, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 8'h4D, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[6] = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 1'b1};

      // reset state, with both requesters already asking
      reset = 1'b0;
      req0_valid = 1'b1; req0_data = 8'h4D;
      req1_valid = 1'b1; req1_data = 8'h0F;
      repeat (3) @(posedge clk);
      to_sample();
      chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("rst_start", {31'd0, tx_start}, 32'd0);
      chk("rst_data", {24'd0, tx_data}, 32'd0);
      chk("rst_grant", {31'd0, grant}, 32'd0);
      chk("rst_active", {31'd0, active}, 32'd0);
      chk("rst_tmo", {31'd0, tmo_err}, 32'd0);
      to_drive();
      reset = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      to_sample();
      chk("post_rst_active", {31'd0, active}, 32'd0);

      // table-driven transfers: contention order, single requests, back-pressure
      for (int i = 0; i < 9; i++) begin
         run_xfer(tbl[i], $sformatf("vec%0d", i));
      end

      // timeout: transmitter never goes busy; requester drops valid after acceptance
      begin
         exp_t e;
         uart_en = 1'b0;
         to_drive();
         req0_valid = 1'b1; req0_data = 8'hC3;
         req1_valid = 1'b0;
         to_sample();
         chk("tmo_ready", {30'd0, req1_ready, req0_ready}, 32'd1);
         e.g = 1'b0; e.d = 8'hC3;
         sb_q.push_back(e);
         to_drive();
         req0_valid = 1'b0;
         to_sample();
         chk("tmo_start", {31'd0, tx_start}, 32'd1);
         for (int k = 1; k <= 16; k++) begin
            to_drive();
            to_sample();
            chk($sformatf("tmo_err_c%0d", k), {31'd0, tmo_err}, (k >= 16) ? 32'd1 : 32'd0);
            chk($sformatf("tmo_active_c%0d", k), {31'd0, active}, (k >= 16) ? 32'd0 : 32'd1);
         end
         uart_en = 1'b1;
      end

      // still serviced after a timeout; pointer untouched by the timed-out transfer
      run_xfer('{1'b1, 8'h77, 1'b1, 8'h88, 1'b0, 1'b0}, "post_tmo");
      chk("tmo_sticky", {31'd0, tmo_err}, 32'd1);

      // reset in WAIT_DONE
      begin
         exp_t e;
         logic g;
         g = FIXED ? 1'b0 : 1'b1;
         to_drive();
         req0_valid = 1'b1; req0_data = 8'hF0;
         req1_valid = 1'b1; req1_data = 8'h0F;
         to_sample();
         chk("mid_ready", {30'd0, req1_ready, req0_ready}, g ? 32'd2 : 32'd1);
         e.g = g; e.d = g ? 8'h0F : 8'hF0;
         sb_q.push_back(e);
         repeat (6) begin
            to_drive();
            to_sample();
         end
         chk("mid_active", {31'd0, active}, 32'd1);
         #1;
         reset = 1'b0;
         #1;
         chk("mid_rst_start", {31'd0, tx_start}, 32'd0);
         chk("mid_rst_data", {24'd0, tx_data}, 32'd0);
         chk("mid_rst_grant", {31'd0, grant}, 32'd0);
         chk("mid_rst_active", {31'd0, active}, 32'd0);
         chk("mid_rst_tmo", {31'd0, tmo_err}, 32'd0);
         chk("mid_rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
         to_drive();
         req0_valid = 1'b0;
         req1_valid = 1'b0;
         to_drive();
         reset = 1'b1;
         to_sample();
         chk("mid_rel_active", {31'd0, active}, 32'd0);
      end
      run_xfer('{1'b1, 8'hF0, 1'b1, 8'h0F, 1'b0, 1'b0}, "rel_tie0");
      run_xfer('{1'b1, 8'hF0, 1'b1, 8'h0F, 1'b1, 1'b0}, "rel_tie1");

      to_drive();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      to_sample();
      chk("sb_empty", sb_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
